// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the PC, drives instruction memory and
// feeds decode through a small prefetch FIFO with redirect/flush handling.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 80,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_done,
  output logic        fault
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [32:0] LIMIT = 33'(IMEM_BYTES);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_END   = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [31:0]       fetch_pc, fetch_pc_next, fetch_pc_inc;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_next, wr_ptr, wr_ptr_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              pop, push;

  logic [31:0] pc_mem  [FIFO_DEPTH];
  logic [31:0] ins_mem [FIFO_DEPTH];

  assign fetch_pc_inc = fetch_pc + 32'd4;

  // Next-state: redirect (outside ERROR) flushes and retargets; otherwise fetch/drain.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    rd_ptr_next   = rd_ptr;
    wr_ptr_next   = wr_ptr;
    count_next    = count;
    pop           = (count != '0) && ins_ready;
    push          = (state == ST_FETCH) && ((count < CNT_W'(FIFO_DEPTH)) || pop) && !redirect_valid;

    if (redirect_valid && (state != ST_ERROR)) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
      if (redirect_pc[1:0] != 2'b00) begin
        state_next = ST_ERROR;
      end else begin
        fetch_pc_next = redirect_pc;
        // 33-bit compare so targets near 2^32 cannot alias into range
        state_next    = (({1'b0, redirect_pc} + 33'd4) > LIMIT) ? ST_END : ST_FETCH;
      end
    end else begin
      if (push) begin
        wr_ptr_next   = wr_ptr + PTR_W'(1);
        fetch_pc_next = fetch_pc_inc;
        if (({1'b0, fetch_pc_inc} + 33'd4) > LIMIT) begin
          state_next = ST_END;
        end
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count_next = count + CNT_W'(1);
      end else if (pop && !push) begin
        count_next = count - CNT_W'(1);
      end
    end
  end

  // State, pointers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_FETCH;
      fetch_pc   <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ins_valid  <= 1'b0;
      fetch_done <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_next;
      fetch_pc   <= fetch_pc_next;
      rd_ptr     <= rd_ptr_next;
      wr_ptr     <= wr_ptr_next;
      count      <= count_next;
      ins_valid  <= (count_next != '0);
      fetch_done <= (state_next == ST_END) && (count_next == '0);
      fault      <= (state_next == ST_ERROR);
    end
  end

  // FIFO storage needs no reset; entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= fetch_pc;
      ins_mem[wr_ptr] <= imem_data;
    end
  end

  assign imem_addr = fetch_pc;
  assign ins_out   = ins_mem[rd_ptr];
  assign pc_out    = pc_mem[rd_ptr];

endmodule
